// File: rtl/midi_msg_tx_pkg.sv
// Shared MIDI transmit definitions: baud constant, status classes,
// FSM state encoding and the status-to-message-length decoder.
package midi_pkg;

   localparam int unsigned MIDI_BAUD = 31250;

   typedef enum logic [3:0] {
      NOTE_OFF = 4'h8,
      NOTE_ON  = 4'h9,
      POLY_AT  = 4'hA,
      CC       = 4'hB,
      PC       = 4'hC,
      CH_AT    = 4'hD,
      PITCH    = 4'hE,
      SYSTEM   = 4'hF
   } midi_class_e;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      SEND_STATUS,
      SEND_D1,
      SEND_D2,
      ERR
   } midi_state_e;

   // Total bytes on the wire for a status byte (status included); 0 = not a status byte
   function automatic logic [1:0] midi_msg_len(input logic [7:0] status);
      logic [1:0] len;
      len = 2'd0;
      if (status[7]) begin
         case (status[7:4])
            NOTE_OFF, NOTE_ON, POLY_AT, CC, PITCH: len = 2'd3;
            PC, CH_AT:                             len = 2'd2;
            default: begin
               case (status[3:0])
                  4'h2:       len = 2'd3;
                  4'h1, 4'h3: len = 2'd2;
                  default:    len = 2'd1;
               endcase
            end
         endcase
      end
      return len;
   endfunction

endpackage

// File: rtl/midi_msg_tx_if.sv
// Message handshake bundle between a MIDI message source and midi_msg_tx.
interface midi_msg_tx_if;
   logic       msg_valid;
   logic       msg_ready;
   logic [7:0] msg_status;
   logic [7:0] msg_data1;
   logic [7:0] msg_data2;

   modport master (
      output msg_valid, msg_status, msg_data1, msg_data2,
      input  msg_ready
   );

   modport slave (
      input  msg_valid, msg_status, msg_data1, msg_data2,
      output msg_ready
   );
endinterface

// File: rtl/midi_uart_tx.sv
// Generic 8N1 UART transmitter. A start strobe is honoured while idle or
// during the final cycle of a stop bit, so bytes can run back-to-back.
module midi_uart_tx #(
   parameter int unsigned CLK_PER_BIT = 1600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] byte_i,
   input  logic       start_i,
   output logic       line_o,
   output logic       done_o,
   output logic       busy_o
);

   localparam int unsigned    BW        = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
   localparam logic [BW-1:0]  BAUD_LAST = BW'(CLK_PER_BIT - 1);

   logic [BW-1:0] baud_q;
   logic [3:0]    bit_q;
   logic [7:0]    data_q;
   logic          line_q;
   logic          busy_q;
   logic          bit_end;

   assign bit_end = (baud_q == BAUD_LAST);
   assign done_o  = busy_q && bit_end && (bit_q == 4'd9);
   assign line_o  = line_q;
   assign busy_o  = busy_q;

   // Bit/baud counters; line_q holds the level of the bit currently on the wire
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= 1'b0;
         line_q <= 1'b1;
         baud_q <= '0;
         bit_q  <= '0;
         data_q <= '0;
      end else if (start_i && (!busy_q || done_o)) begin
         busy_q <= 1'b1;
         line_q <= 1'b0;
         baud_q <= '0;
         bit_q  <= '0;
         data_q <= byte_i;
      end else if (busy_q) begin
         if (bit_end) begin
            baud_q <= '0;
            if (bit_q == 4'd9) begin
               busy_q <= 1'b0;
               line_q <= 1'b1;
            end else begin
               bit_q  <= bit_q + 4'd1;
               line_q <= (bit_q == 4'd8) ? 1'b1 : data_q[bit_q[2:0]];
            end
         end else begin
            baud_q <= baud_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/midi_msg_tx.sv
// MIDI OUT message transmitter: accepts a whole message, works out how many
// bytes go on the wire (including running-status suppression) and feeds
// them back-to-back into an 8N1 serialiser.
module midi_msg_tx
   import midi_pkg::*;
#(
   parameter int unsigned CLK_PER_BIT    = 1600,
   parameter bit          RUNNING_STATUS = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   midi_msg_tx_if.slave  msg,
   output logic          midi_out,
   output logic          busy,
   output logic          err_pulse
);

   midi_state_e state_q;
   logic [7:0]  status_q, d1_q, d2_q, rs_q;
   logic [1:0]  len_q;
   logic        rs_valid_q, ready_q, err_q;

   logic [1:0]  len_d;
   logic        is_chan, skip_d;
   logic        tx_start_d, tx_done, tx_busy, tx_line;
   logic [7:0]  tx_byte_d;

   assign len_d   = midi_msg_len(status_q);
   assign is_chan = status_q[7] && (status_q[7:4] != SYSTEM);
   assign skip_d  = RUNNING_STATUS && rs_valid_q && is_chan && (status_q == rs_q);

   assign msg.msg_ready = ready_q;
   assign err_pulse     = err_q;
   assign busy          = tx_busy;
   assign midi_out      = tx_line;

   // Pick the byte handed to the serialiser; starts coincide with the previous byte's done
   always_comb begin
      tx_start_d = 1'b0;
      tx_byte_d  = status_q;
      case (state_q)
         CHECK: if (len_d != 2'd0) begin
            tx_start_d = 1'b1;
            tx_byte_d  = skip_d ? d1_q : status_q;
         end
         SEND_STATUS: if (tx_done && (len_q >= 2'd2)) begin
            tx_start_d = 1'b1;
            tx_byte_d  = d1_q;
         end
         SEND_D1: if (tx_done && (len_q == 2'd3)) begin
            tx_start_d = 1'b1;
            tx_byte_d  = d2_q;
         end
         default: ;
      endcase
   end

   // Message sequencing FSM with capture, running-status tracking and registered flags
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         status_q   <= '0;
         d1_q       <= '0;
         d2_q       <= '0;
         len_q      <= '0;
         rs_q       <= '0;
         rs_valid_q <= 1'b0;
         ready_q    <= 1'b1;
         err_q      <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state_q)
            IDLE: if (msg.msg_valid && ready_q) begin
               status_q <= msg.msg_status;
               d1_q     <= {1'b0, msg.msg_data1[6:0]};
               d2_q     <= {1'b0, msg.msg_data2[6:0]};
               ready_q  <= 1'b0;
               state_q  <= CHECK;
            end
            CHECK: begin
               len_q <= len_d;
               if (len_d == 2'd0) begin
                  err_q   <= 1'b1;
                  state_q <= ERR;
               end else begin
                  state_q <= skip_d ? SEND_D1 : SEND_STATUS;
                  if (is_chan) begin
                     rs_q       <= status_q;
                     rs_valid_q <= 1'b1;
                  end else if (!status_q[3]) begin
                     rs_valid_q <= 1'b0;
                  end
               end
            end
            SEND_STATUS: if (tx_done) begin
               if (len_q >= 2'd2) begin
                  state_q <= SEND_D1;
               end else begin
                  state_q <= IDLE;
                  ready_q <= 1'b1;
               end
            end
            SEND_D1: if (tx_done) begin
               if (len_q == 2'd3) begin
                  state_q <= SEND_D2;
               end else begin
                  state_q <= IDLE;
                  ready_q <= 1'b1;
               end
            end
            SEND_D2: if (tx_done) begin
               state_q <= IDLE;
               ready_q <= 1'b1;
            end
            ERR: begin
               state_q <= IDLE;
               ready_q <= 1'b1;
            end
            default: begin
               state_q <= IDLE;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   midi_uart_tx #(
      .CLK_PER_BIT (CLK_PER_BIT)
   ) u_uart (
      .clk     (clk),
      .rst     (rst),
      .byte_i  (tx_byte_d),
      .start_i (tx_start_d),
      .line_o  (tx_line),
      .done_o  (tx_done),
      .busy_o  (tx_busy)
   );

endmodule

// File: tb/tb_midi_msg_tx.sv
// Bench for midi_msg_tx: running-status and plain instances share stimulus,
// serial decoders check bytes against per-instance expected queues, and a
// default-rate instance checks the real bit width.
module tb_midi_msg_tx;

   localparam int unsigned CPB = 4;

   logic clk = 1'b0;
   logic rst;
   always #10 clk = ~clk;

   midi_msg_tx_if ifa ();
   midi_msg_tx_if ifb ();
   midi_msg_tx_if ifc ();

   logic mo_a, mo_b, mo_c, busy_a, busy_b, busy_c, err_a, err_b, err_c;

   midi_msg_tx #(.CLK_PER_BIT(CPB), .RUNNING_STATUS(1'b1)) dut_a (
      .clk(clk), .rst(rst), .msg(ifa), .midi_out(mo_a), .busy(busy_a), .err_pulse(err_a));
   midi_msg_tx #(.CLK_PER_BIT(CPB), .RUNNING_STATUS(1'b0)) dut_b (
      .clk(clk), .rst(rst), .msg(ifb), .midi_out(mo_b), .busy(busy_b), .err_pulse(err_b));
   midi_msg_tx dut_c (
      .clk(clk), .rst(rst), .msg(ifc), .midi_out(mo_c), .busy(busy_c), .err_pulse(err_c));

   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [7:0]  qa[$];
   logic [7:0]  qb[$];
   int unsigned rst_gen = 0;
   logic [7:0]  rsa = '0;
   bit          rsa_v = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int unsigned tb_len(input logic [7:0] s);
      if (s < 8'h80) return 0;
      if (s < 8'hC0 || (s >= 8'hE0 && s < 8'hF0) || s == 8'hF2) return 3;
      if (s < 8'hE0 || s == 8'hF1 || s == 8'hF3) return 2;
      return 1;
   endfunction

   // Expected wire bytes for both instances; returns byte count for the running-status one
   task automatic model(input logic [7:0] st, d1, d2, output int unsigned na);
      int unsigned len;
      len = tb_len(st);
      na  = 0;
      if (len != 0) begin
         if (!(rsa_v && st < 8'hF0 && st == rsa)) begin qa.push_back(st); na++; end
         qb.push_back(st);
         if (len >= 2) begin qa.push_back({1'b0, d1[6:0]}); qb.push_back({1'b0, d1[6:0]}); na++; end
         if (len == 3) begin qa.push_back({1'b0, d2[6:0]}); qb.push_back({1'b0, d2[6:0]}); na++; end
         if (st < 8'hF0) begin rsa = st; rsa_v = 1'b1; end
         else if (st < 8'hF8) rsa_v = 1'b0;
      end
   endtask

   // Decode one frame whose falling edge was just seen; samples near mid-bit
   task automatic rx_frame(input bit sel, output logic [7:0] b, output logic stp);
      repeat (CPB / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         repeat (CPB) @(negedge clk);
         b[i] = sel ? mo_b : mo_a;
      end
      repeat (CPB) @(negedge clk);
      stp = sel ? mo_b : mo_a;
   endtask

   task automatic score(input bit sel, input logic [7:0] b, input logic stp);
      logic [7:0] exp;
      check(sel ? "stop_b" : "stop_a", stp, 1);
      checks++;
      if ((sel ? qb.size() : qa.size()) == 0) begin
         errors++;
         $error("FAIL %s: observed byte 0x%0h expected no byte", sel ? "extra_b" : "extra_a", b);
      end else begin
         exp = sel ? qb.pop_front() : qa.pop_front();
         assert (b === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", sel ? "byte_b" : "byte_a", b, exp);
         end
      end
   endtask

   logic [7:0]  rxa_b, rxb_b;
   logic        rxa_s, rxb_s;
   int unsigned rxa_g, rxb_g;

   // Serial decoder for the running-status instance
   initial forever begin
      @(negedge mo_a);
      rxa_g = rst_gen;
      rx_frame(1'b0, rxa_b, rxa_s);
      if (rxa_g == rst_gen) score(1'b0, rxa_b, rxa_s);
   end

   // Serial decoder for the always-send-status instance
   initial forever begin
      @(negedge mo_b);
      rxb_g = rst_gen;
      rx_frame(1'b1, rxb_b, rxb_s);
      if (rxb_g == rst_gen) score(1'b1, rxb_b, rxb_s);
   end

   task automatic send(input logic [7:0] st, d1, d2, output int unsigned na);
      int n = 0;
      while (!(ifa.msg_ready === 1'b1 && ifb.msg_ready === 1'b1) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("ready_wait", n < 2000, 1);
      ifa.msg_status = st; ifa.msg_data1 = d1; ifa.msg_data2 = d2; ifa.msg_valid = 1'b1;
      ifb.msg_status = st; ifb.msg_data1 = d1; ifb.msg_data2 = d2; ifb.msg_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ifa.msg_valid = 1'b0;
      ifb.msg_valid = 1'b0;
      model(st, d1, d2, na);
   endtask

   // Called half a cycle after acceptance; times the busy window of the running-status instance
   task automatic measure(input string tag, input int unsigned nbytes);
      int unsigned n = 0, bad = 0;
      int          first = -1;
      logic        first_line = 1'b1;
      bit          done = 1'b0;
      check({tag, "_ready_low"}, ifa.msg_ready, 0);
      for (int i = 0; i < 2000 && !done; i++) begin
         @(negedge clk);
         if (busy_a === 1'b1) begin
            if (first < 0) begin first = i; first_line = mo_a; end
            n++;
            if (ifa.msg_ready !== 1'b0) bad++;
         end else if (n > 0) begin
            done = 1'b1;
         end
      end
      check({tag, "_first_busy"}, first, 0);
      check({tag, "_start_bit"}, first_line, 0);
      check({tag, "_busy_cycles"}, n, nbytes * 10 * CPB);
      check({tag, "_ready_in_busy"}, bad, 0);
      check({tag, "_ready_at_end"}, ifa.msg_ready, 1);
   endtask

   int unsigned na;
   longint      t0, t1;
   int          k;

   initial begin
      rst = 1'b1;
      ifa.msg_valid = 1'b0; ifa.msg_status = '0; ifa.msg_data1 = '0; ifa.msg_data2 = '0;
      ifb.msg_valid = 1'b0; ifb.msg_status = '0; ifb.msg_data1 = '0; ifb.msg_data2 = '0;
      ifc.msg_valid = 1'b0; ifc.msg_status = '0; ifc.msg_data1 = '0; ifc.msg_data2 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_midi_out", mo_a, 1);
      check("rst_ready", ifa.msg_ready, 1);
      check("rst_busy", busy_a, 0);
      check("rst_err", err_a, 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Note On, full message
      send(8'h90, 8'h3C, 8'h64, na); check("t1_nbytes", na, 3); measure("t1", na);
      // Repeated status is suppressed on A only
      send(8'h90, 8'h40, 8'h64, na); check("t2_nbytes", na, 2); measure("t2", na);
      // Realtime byte keeps running status
      send(8'h90, 8'h3C, 8'h64, na); measure("t3a", na);
      send(8'hF8, 8'h11, 8'h22, na); check("t3_rt_nbytes", na, 1); measure("t3b", na);
      send(8'h90, 8'h3E, 8'h00, na); check("t3_nbytes", na, 2); measure("t3c", na);
      // Program change: data2 ignored
      send(8'hC5, 8'h07, 8'h55, na); check("t4_nbytes", na, 2); measure("t4", na);
      // Data bit 7 stripped
      send(8'h80, 8'hFF, 8'h80, na); measure("mask", na);
      // System common clears running status
      send(8'hF2, 8'h01, 8'h02, na); measure("f2", na);
      send(8'h90, 8'h3C, 8'h64, na); check("f2_clear_nbytes", na, 3); measure("f2b", na);

      // Invalid status
      send(8'h3C, 8'h01, 8'h02, na);
      check("t5_err_n0", err_a, 0);
      check("t5_ready_n0", ifa.msg_ready, 0);
      @(negedge clk);
      check("t5_err_n1", err_a, 1);
      check("t5_err_b_n1", err_b, 1);
      check("t5_ready_n1", ifa.msg_ready, 0);
      check("t5_line_n1", mo_a, 1);
      @(negedge clk);
      check("t5_err_n2", err_a, 0);
      check("t5_ready_n2", ifa.msg_ready, 1);
      check("t5_line_n2", mo_a, 1);
      check("t5_busy_n2", busy_a, 0);

      // Reset in the second byte
      send(8'h90, 8'h3C, 8'h64, na);
      repeat (60) @(negedge clk);
      rst = 1'b1;
      rst_gen++;
      qa.delete();
      qb.delete();
      rsa_v = 1'b0;
      @(negedge clk);
      check("t6_line_a", mo_a, 1);
      check("t6_line_b", mo_b, 1);
      check("t6_ready", ifa.msg_ready, 1);
      check("t6_busy", busy_a, 0);
      rst = 1'b0;
      repeat (60) @(negedge clk);
      send(8'h90, 8'h3C, 8'h64, na); check("t6_nbytes", na, 3); measure("t6", na);

      k = 0;
      while ((qa.size() != 0 || qb.size() != 0) && k < 400) begin @(negedge clk); k++; end
      check("drain_a", qa.size(), 0);
      check("drain_b", qb.size(), 0);

      // Default rate: start bit of FF is exactly one bit wide
      ifc.msg_status = 8'hFF; ifc.msg_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ifc.msg_valid = 1'b0;
      k = 0;
      while (mo_c !== 1'b0 && k < 10) begin @(negedge clk); k++; end
      check("t7_fall", mo_c, 0);
      t0 = $time;
      k = 0;
      while (mo_c !== 1'b1 && k < 3000) begin @(negedge clk); k++; end
      t1 = $time;
      check("t7_bit_width", 32'(t1 - t0), 32000);
      check("t7_busy", busy_c, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
